// File: rtl/deflate_bit_packer.sv
// LSB-first bit packer: appends 0..32-bit codes into a 64-bit staging buffer and
// emits 32-bit words over valid/ready, draining a zero-padded tagged final word.
module deflate_bit_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_code,
  input  logic [5:0]  in_len,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [5:0]  out_nbits
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state;
  logic [63:0] stage;
  logic [5:0]  fill;

  logic        out_fire;
  logic        in_fire;
  logic [63:0] len_mask;
  logic [63:0] code_bits;
  logic [63:0] base;
  logic [5:0]  base_fill;
  logic [63:0] stage_next;
  logic [5:0]  fill_next;

  always_comb begin
    out_valid = (fill >= 6'd32) || (state == DRAIN);
    out_last  = (state == DRAIN) && (fill <= 6'd32);
    out_nbits = out_last ? fill : 6'd32;
    out_data  = stage[31:0];
    out_fire  = out_valid && out_ready;
    in_ready  = !rst && (state == RUN) && ((fill < 6'd32) || out_fire);
    in_fire   = in_valid && in_ready;
  end

  // A leaving word is shifted out before the new code lands, so the insert
  // position is the post-shift fill.
  always_comb begin
    len_mask  = (64'd1 << in_len) - 64'd1;
    code_bits = {32'd0, in_code} & len_mask;
    if (out_fire) begin
      base      = {32'd0, stage[63:32]};
      base_fill = out_last ? 6'd0 : fill - 6'd32;
    end else begin
      base      = stage;
      base_fill = fill;
    end
    stage_next = base;
    fill_next  = base_fill;
    if (in_fire) begin
      stage_next = base | (code_bits << base_fill);
      fill_next  = base_fill + in_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      stage <= '0;
      fill  <= '0;
    end else begin
      stage <= stage_next;
      fill  <= fill_next;
      case (state)
        RUN:   if (in_fire && in_last) state <= DRAIN;
        DRAIN: if (out_fire && out_last) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_deflate_bit_packer.sv
// Scoreboard bench: a bit-queue model predicts every output word; a negedge
// monitor pops and compares, plus directed checks of timing and edge cases.
module tb_deflate_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_code;
  logic [5:0]  in_len;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [5:0]  out_nbits;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [5:0]  nbits;
  } word_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  word_t       exp_q[$];
  bit          bq[$];
  bit          rand_bp = 1'b0;

  logic        stalled = 1'b0;
  logic [31:0] st_data;
  logic        st_last;
  logic [5:0]  st_nbits;
  word_t       mon_w;

  always #5 clk = ~clk;

  deflate_bit_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_len    (in_len),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_nbits (out_nbits)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: the stream is a plain queue of bits, cut into 32-bit words.
  task automatic emit(int n, logic last);
    word_t w;
    w.data  = '0;
    w.last  = last;
    w.nbits = 6'(n);
    for (int i = 0; i < n; i++) w.data[i] = bq.pop_front();
    exp_q.push_back(w);
  endtask

  task automatic model_push(logic [31:0] code, logic [5:0] len, logic last);
    for (int i = 0; i < int'(len); i++) bq.push_back(code[i]);
    if (!last) begin
      while (bq.size() >= 32) emit(32, 1'b0);
    end else begin
      while (bq.size() > 32) emit(32, 1'b0);
      emit(bq.size(), 1'b1);
    end
  endtask

  task automatic send(logic [31:0] code, logic [5:0] len, logic last);
    int unsigned waited = 0;
    in_valid = 1'b1;
    in_code  = code;
    in_len   = len;
    in_last  = last;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      if (waited > 2000) begin
        n_checks++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "input never accepted");
      end
      @(posedge clk); #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    model_push(code, len, last);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_code  = $urandom;
    in_len   = 6'($urandom_range(0, 32));
    in_last  = 1'($urandom_range(0, 1));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("hold_stable", {24'd0, out_valid, out_last, out_nbits, out_data},
              {24'd0, 1'b1, st_last, st_nbits, st_data});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_extra: got word 0x%0h, expected no word", out_data);
        end else begin
          mon_w = exp_q.pop_front();
          check("sb_word", {25'd0, out_last, out_nbits, out_data},
                {25'd0, mon_w.last, mon_w.nbits, mon_w.data});
        end
      end
      stalled  = out_valid && !out_ready;
      st_data  = out_data;
      st_last  = out_last;
      st_nbits = out_nbits;
    end
  end

  initial begin
    int unsigned k;
    rst = 1'b1; in_valid = 1'b0; in_code = '0; in_len = '0; in_last = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_out_data", out_data, 0);
    check("post_rst_out_last", out_last, 0);
    check("post_rst_out_nbits", out_nbits, 32);

    // basic pack
    out_ready = 1'b1;
    send(32'h5, 6'd3, 1'b0);
    send(32'h1F, 6'd5, 1'b0);
    send(32'hFFFFFF, 6'd24, 1'b0);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 32'hFFFFFFFD);
    check("t1_nbits", out_nbits, 32);
    check("t1_last", out_last, 0);
    @(posedge clk); #1;
    check("t1_empty", out_valid, 0);

    // partial flush
    send(32'h3, 6'd2, 1'b1);
    check("t2_valid", out_valid, 1);
    check("t2_data", out_data, 32'h3);
    check("t2_last", out_last, 1);
    check("t2_nbits", out_nbits, 2);
    @(posedge clk); #1;
    check("t2_empty", out_valid, 0);
    check("t2_run", in_ready, 1);

    // backpressure and simultaneous fire
    out_ready = 1'b0;
    send(32'hA5A51234, 6'd32, 1'b0);
    in_valid = 1'b1; in_code = 32'h0BADCAFE; in_len = 6'd32; in_last = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("t3_blocked", in_ready, 0);
      check("t3_hold_a", out_data, 32'hA5A51234);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_both_fire", in_ready, 1);
    if (in_ready) model_push(32'h0BADCAFE, 6'd32, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t3_data_b", out_data, 32'h0BADCAFE);
    check("t3_valid_b", out_valid, 1);
    @(posedge clk); #1;
    check("t3_empty", out_valid, 0);

    // straddle, drain more than one word
    send(32'h7FFFFFFF, 6'd31, 1'b0);
    send(32'hFFFFFFFF, 6'd32, 1'b1);
    check("t4_w0_data", out_data, 32'hFFFFFFFF);
    check("t4_w0_last", out_last, 0);
    @(posedge clk); #1;
    check("t4_w1_data", out_data, 32'h7FFFFFFF);
    check("t4_w1_last", out_last, 1);
    check("t4_w1_nbits", out_nbits, 31);
    @(posedge clk); #1;
    check("t4_empty", out_valid, 0);

    // zero-length last, masking, exact 32-bit final word
    send(32'hFFFFFFFF, 6'd0, 1'b1);
    check("t5_zero_valid", out_valid, 1);
    check("t5_zero_last", out_last, 1);
    check("t5_zero_nbits", out_nbits, 0);
    check("t5_zero_data", out_data, 0);
    @(posedge clk); #1;
    check("t5_zero_run", in_ready, 1);
    send(32'hFFFFFFFF, 6'd4, 1'b0);
    send(32'hFFFF0000, 6'd28, 1'b1);
    check("t5_mask_data", out_data, 32'hFFF0000F);
    check("t5_full_last", out_last, 1);
    check("t5_full_nbits", out_nbits, 32);
    @(posedge clk); #1;

    // reset mid-stream at fill=40
    out_ready = 1'b0;
    send(32'h00ABCDEF, 6'd24, 1'b0);
    send(32'h00001234, 6'd16, 1'b0);
    check("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    bq.delete();
    exp_q.delete();
    @(posedge clk); #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("t6_in_ready", in_ready, 1);
    check("t6_nbits", out_nbits, 32);
    out_ready = 1'b1;
    send(32'hCAFEF00D, 6'd32, 1'b0);
    check("t6_data", out_data, 32'hCAFEF00D);
    @(posedge clk); #1;

    // randomized stream under random backpressure
    rand_bp = 1'b1;
    repeat (400) send($urandom, 6'($urandom_range(0, 32)), ($urandom_range(0, 19) == 0));
    send($urandom, 6'($urandom_range(0, 32)), 1'b1);
    rand_bp = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_idle", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
